deca_ddr3_status_monitor: RTL and testbench
===========================================

Name: deca_ddr3_status_monitor

Overview:
Upstream feeder for the 4-bit DDR3 status PIO input. It takes raw, asynchronous status strobes from the DDR3 controller/PHY and its PLL, then synchronises and glitch-filters them. It tracks bring-up with a small state machine and drives a registered 4-bit status word onto the PIO's in_port. Sticky fault bits persist until software or a host pulse clears them.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per raw input (minimum 2).
FILTER_CYCLES, 4, consecutive stable cycles required before a filtered bit changes (minimum 1).
TIMEOUT_CYCLES, 50000000, CALIBRATING cycles allowed before a timeout fault.
TIMEOUT_W, 26, timeout counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; the single clock for the block
reset_n  in  1  asynchronous, active-low reset
pll_locked  in  1  raw DDR3 PLL lock, asynchronous to clk
local_init_done  in  1  raw controller init-done, asynchronous
local_cal_success  in  1  raw calibration success, asynchronous
local_cal_fail  in  1  raw calibration fail, asynchronous
clear_sticky  in  1  single-cycle pulse; clears sticky faults
status  out  4  to PIO in_port: [0] ready, [1] cal_success_f, [2] cal_fail_sticky, [3] pll_lost_sticky
state  out  2  debug: current FSM state encoding
status_change  out  1  one-cycle pulse when status differs from its previous value

Behaviour:
- Reset (async assert, sync release via flops): sync chains = 0, filtered bits = 0, filter counters = 0, state = WAIT_PLL (2'd0), timeout counter = 0, status = 4'h0, status_change = 0.
- Sync: each raw input passes through SYNC_STAGES flops. No combinational path from raw inputs to any output.
- Filter, per signal:
  - Counter clears whenever the synced value equals the filtered value.
  - Otherwise the counter increments; on reaching FILTER_CYCLES-1 the filtered bit takes the synced value and the counter clears.
  - A one-cycle glitch shorter than FILTER_CYCLES never propagates.
  - Latency from raw edge to filtered edge = SYNC_STAGES + FILTER_CYCLES cycles.
- FSM states (encoding): WAIT_PLL=0, CALIBRATING=1, READY=2, FAILED=3.
  - WAIT_PLL -> CALIBRATING when pll_f = 1; the timeout counter loads 0 on entry.
  - CALIBRATING:
    - if cal_fail_f = 1, or the counter reaches TIMEOUT_CYCLES-1 -> FAILED, set cal_fail_sticky;
    - else if init_done_f & cal_success_f -> READY;
    - else if pll_f = 0 -> WAIT_PLL, set pll_lost_sticky.
    - Fail takes priority when fail and success are filtered-high in the same cycle.
    - The counter increments only in CALIBRATING and saturates; it never wraps.
  - READY:
    - pll_f = 0 -> WAIT_PLL, set pll_lost_sticky;
    - cal_fail_f = 1 -> FAILED, set cal_fail_sticky;
    - if both occur together, go to FAILED and set both stickies.
  - FAILED: holds until clear_sticky = 1, then -> WAIT_PLL.
- Sticky bits:
  - Set events win over a same-cycle clear_sticky.
  - A clear pulse otherwise zeroes both stickies the next cycle.
  - clear_sticky in any state other than FAILED clears stickies only; no state change.
- status register, updated every cycle:
  - status[0] = (next_state == READY);
  - status[1] = cal_success_f;
  - status[2] = cal_fail_sticky;
  - status[3] = pll_lost_sticky.
  - The output is registered, so a filtered change appears on status one cycle later.
- status_change = 1 for exactly one cycle after any status bit changes. Not asserted on reset release.
- Reset mid-operation returns every register to its reset value immediately; no partial state survives.

Decomposition:
- Shared package deca_ddr3_status_pkg:
  - FSM state typedef/localparams (WAIT_PLL..FAILED);
  - status bit index constants (STAT_READY=0, STAT_CAL_OK=1, STAT_CAL_FAIL=2, STAT_PLL_LOST=3).
- One sub-module, deca_status_sync_filter: one-bit synchroniser plus stability filter with parameters SYNC_STAGES and FILTER_CYCLES, instantiated four times.

Test Plan:
All scenarios use SYNC_STAGES=2, FILTER_CYCLES=4, TIMEOUT_CYCLES=100.
1. Normal bring-up: after reset, raise pll_locked, then init_done and cal_success 20 cycles later -> state 0->1->2; status = 4'h3; one status_change pulse per status transition.
2. Glitch rejection: pll_locked high for 3 cycles, then low -> state stays WAIT_PLL, status = 4'h0, no status_change.
3. Timeout: pll_locked high, no calibration result -> FAILED exactly 100 cycles after entering CALIBRATING; status = 4'h4; state = 3.
4. Simultaneous cal_fail and cal_success in CALIBRATING -> FAILED, status[2] = 1, status[0] = 0. clear_sticky then gives status = 4'h0 and state = WAIT_PLL (immediately re-entering CALIBRATING if pll is still locked).
5. PLL loss in READY: drop pll_locked for 10 cycles -> state WAIT_PLL, status[3] = 1, status[0] = 0. clear_sticky in the same cycle as a new set event -> sticky remains 1.
6. Assert reset_n low mid-CALIBRATING with the counter at 50 -> all outputs 0 asynchronously. After release the counter restarts from 0, and the timeout fires 100 cycles after re-entering CALIBRATING.

Source files
------------

// File: rtl/deca_ddr3_status_pkg.sv
// Shared definitions for the DDR3 status monitor: FSM encodings, status bit
// positions and a helper that assembles the status word.
package deca_ddr3_status_pkg;

  typedef logic [1:0] state_t;

  // Bring-up FSM encodings; software decodes these from the debug port.
  localparam state_t WAIT_PLL    = 2'd0;
  localparam state_t CALIBRATING = 2'd1;
  localparam state_t READY       = 2'd2;
  localparam state_t FAILED      = 2'd3;

  // Bit positions inside the 4-bit PIO status word.
  localparam int unsigned STAT_READY    = 0;
  localparam int unsigned STAT_CAL_OK   = 1;
  localparam int unsigned STAT_CAL_FAIL = 2;
  localparam int unsigned STAT_PLL_LOST = 3;

  localparam int unsigned STATUS_W = 4;

  typedef logic [STATUS_W-1:0] status_t;

  // Place each flag at its documented bit position.
  function automatic status_t pack_status(input logic ready,
                                          input logic cal_ok,
                                          input logic cal_fail,
                                          input logic pll_lost);
    status_t s;
    s                = '0;
    s[STAT_READY]    = ready;
    s[STAT_CAL_OK]   = cal_ok;
    s[STAT_CAL_FAIL] = cal_fail;
    s[STAT_PLL_LOST] = pll_lost;
    return s;
  endfunction

endpackage

// File: rtl/deca_ddr3_status_monitor_if.sv
// Signal bundle between the DDR3 raw status sources and the PIO status word.
// master: the side producing raw strobes and consuming status.
// slave:  the monitor itself.
interface deca_ddr3_status_monitor_if;
  import deca_ddr3_status_pkg::*;

  // Raw, asynchronous strobes from the PHY/controller and its PLL.
  logic    pll_locked;
  logic    local_init_done;
  logic    local_cal_success;
  logic    local_cal_fail;
  // Synchronous single-cycle pulse from software/host.
  logic    clear_sticky;

  // Registered outputs toward the PIO in_port and debug.
  status_t status;
  state_t  state;
  logic    status_change;

  modport master (
    output pll_locked,
    output local_init_done,
    output local_cal_success,
    output local_cal_fail,
    output clear_sticky,
    input  status,
    input  state,
    input  status_change
  );

  modport slave (
    input  pll_locked,
    input  local_init_done,
    input  local_cal_success,
    input  local_cal_fail,
    input  clear_sticky,
    output status,
    output state,
    output status_change
  );

endinterface

// File: rtl/deca_status_sync_filter.sv
// One-bit synchroniser followed by a stability filter. The filtered output
// only follows the synchronised input after it has disagreed with it for
// FILTER_CYCLES consecutive cycles, so short glitches are swallowed.
module deca_status_sync_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_filt   = r_filt;

  // Synchroniser chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count consecutive disagreeing cycles; adopt the new level on the last one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/deca_ddr3_status_monitor.sv
// DDR3 bring-up status monitor. Cleans the raw PLL/controller strobes, tracks
// bring-up with a four-state FSM, keeps sticky fault flags and presents a
// registered 4-bit status word plus a change pulse to the PIO.
module deca_ddr3_status_monitor
  import deca_ddr3_status_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TIMEOUT_W      = 26
) (
  input  logic                        clk,
  input  logic                        reset_n,
  deca_ddr3_status_monitor_if.slave   bus
);

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TimeoutMax  = '1;

  logic                 w_pll_f;
  logic                 w_init_f;
  logic                 w_cal_ok_f;
  logic                 w_cal_fail_f;

  state_t               r_state;
  state_t               w_next_state;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic                 r_fail_sticky;
  logic                 r_lost_sticky;
  logic                 w_fail_sticky_d;
  logic                 w_lost_sticky_d;
  logic                 w_set_fail;
  logic                 w_set_lost;
  status_t              r_status;
  status_t              w_status_d;
  logic                 r_status_change;

  deca_status_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_flt_pll (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.pll_locked),
    .o_filt  (w_pll_f)
  );

  deca_status_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_flt_init (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.local_init_done),
    .o_filt  (w_init_f)
  );

  deca_status_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_flt_cal_ok (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.local_cal_success),
    .o_filt  (w_cal_ok_f)
  );

  deca_status_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_flt_cal_fail (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.local_cal_fail),
    .o_filt  (w_cal_fail_f)
  );

  // Next-state decode and sticky-fault set events.
  always_comb begin
    w_next_state = r_state;
    w_set_fail   = 1'b0;
    w_set_lost   = 1'b0;
    case (r_state)
      WAIT_PLL: begin
        if (w_pll_f) begin
          w_next_state = CALIBRATING;
        end
      end
      CALIBRATING: begin
        // Failure outranks a same-cycle success.
        if (w_cal_fail_f || (r_tmo_cnt >= TimeoutLast)) begin
          w_next_state = FAILED;
          w_set_fail   = 1'b1;
        end else if (w_init_f && w_cal_ok_f) begin
          w_next_state = READY;
        end else if (!w_pll_f) begin
          w_next_state = WAIT_PLL;
          w_set_lost   = 1'b1;
        end
      end
      READY: begin
        // Both faults may be recorded at once; FAILED wins the state.
        w_set_lost = !w_pll_f;
        w_set_fail = w_cal_fail_f;
        if (w_cal_fail_f) begin
          w_next_state = FAILED;
        end else if (!w_pll_f) begin
          w_next_state = WAIT_PLL;
        end
      end
      FAILED: begin
        if (bus.clear_sticky) begin
          w_next_state = WAIT_PLL;
        end
      end
      default: begin
        w_next_state = WAIT_PLL;
      end
    endcase
  end

  // Sticky next values: a set event beats a same-cycle clear.
  always_comb begin
    w_fail_sticky_d = r_fail_sticky;
    w_lost_sticky_d = r_lost_sticky;
    if (w_set_fail) begin
      w_fail_sticky_d = 1'b1;
    end else if (bus.clear_sticky) begin
      w_fail_sticky_d = 1'b0;
    end
    if (w_set_lost) begin
      w_lost_sticky_d = 1'b1;
    end else if (bus.clear_sticky) begin
      w_lost_sticky_d = 1'b0;
    end
  end

  // Status word built from next-state values so it lines up with r_state.
  always_comb begin
    w_status_d = pack_status(w_next_state == READY, w_cal_ok_f,
                             w_fail_sticky_d, w_lost_sticky_d);
  end

  // FSM and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= WAIT_PLL;
      r_fail_sticky <= 1'b0;
      r_lost_sticky <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_fail_sticky <= w_fail_sticky_d;
      r_lost_sticky <= w_lost_sticky_d;
    end
  end

  // Calibration timeout counter: restarts on entry, saturates, never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != CALIBRATING) && (w_next_state == CALIBRATING)) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == CALIBRATING) && (r_tmo_cnt != TimeoutMax)) begin
      r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
    end
  end

  // Registered status word and its change pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status        <= '0;
      r_status_change <= 1'b0;
    end else begin
      r_status        <= w_status_d;
      r_status_change <= (w_status_d != r_status);
    end
  end

  assign bus.status        = r_status;
  assign bus.state         = r_state;
  assign bus.status_change = r_status_change;

endmodule

// File: tb/tb_deca_ddr3_status_monitor.sv
// Bench for deca_ddr3_status_monitor. Expected status words are queued when a
// status transition is provoked and checked when status_change fires.
module tb_deca_ddr3_status_monitor;
  import deca_ddr3_status_pkg::*;

  logic clk;
  logic reset_n;

  int   n_vec;
  int   n_err;
  int   n_pulse;
  logic [3:0] exp_q[$];

  deca_ddr3_status_monitor_if u_if ();

  deca_ddr3_status_monitor #(
    .SYNC_STAGES    (2),
    .FILTER_CYCLES  (4),
    .TIMEOUT_CYCLES (100),
    .TIMEOUT_W      (8)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every status_change pulse must match the next queued word.
  task automatic monitor();
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (u_if.status_change === 1'b1) begin
        n_pulse++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: status_change with status=%h, none expected",
                   u_if.status);
        end else begin
          exp = exp_q.pop_front();
          if (u_if.status !== exp) begin
            n_err++;
            $display("FAIL sb_status: status=%h expected=%h", u_if.status, exp);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset_n                = 1'b0;
    u_if.pll_locked        = 1'b0;
    u_if.local_init_done   = 1'b0;
    u_if.local_cal_success = 1'b0;
    u_if.local_cal_fail    = 1'b0;
    u_if.clear_sticky      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int p0;
    p0 = n_pulse;
    reset_n                = 1'b0;
    u_if.pll_locked        = 1'b0;
    u_if.local_init_done   = 1'b0;
    u_if.local_cal_success = 1'b0;
    u_if.local_cal_fail    = 1'b0;
    u_if.clear_sticky      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.status !== 4'h0) begin
      n_err++; $display("FAIL rst_status: got %h want 0", u_if.status);
    end
    n_vec++;
    if (u_if.state !== WAIT_PLL) begin
      n_err++; $display("FAIL rst_state: got %0d want 0", u_if.state);
    end
    n_vec++;
    if (u_if.status_change !== 1'b0) begin
      n_err++; $display("FAIL rst_change: got %b want 0", u_if.status_change);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.status !== 4'h0) || (u_if.state !== WAIT_PLL)) begin
      n_err++;
      $display("FAIL rst_release: status=%h state=%0d want 0/0", u_if.status, u_if.state);
    end
    n_vec++;
    if (n_pulse - p0 !== 0) begin
      n_err++; $display("FAIL rst_pulses: got %0d want 0", n_pulse - p0);
    end
  endtask

  task automatic test_bring_up();
    int p0;
    apply_reset();
    p0 = n_pulse;
    u_if.pll_locked = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== WAIT_PLL) begin
      n_err++; $display("FAIL up_early: state=%0d want 0", u_if.state);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL up_cal: state=%0d want 1", u_if.state);
    end
    repeat (20) @(posedge clk);
    #1;
    exp_q.push_back(4'h3);
    u_if.local_init_done   = 1'b1;
    u_if.local_cal_success = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL up_pre_ready: state=%0d want 1", u_if.state);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== READY) || (u_if.status !== 4'h3)) begin
      n_err++;
      $display("FAIL up_ready: state=%0d status=%h want 2/3", u_if.state, u_if.status);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((exp_q.size() !== 0) || (n_pulse - p0 !== 1)) begin
      n_err++;
      $display("FAIL up_pulses: pending=%0d pulses=%0d want 0/1", exp_q.size(), n_pulse - p0);
    end
  endtask

  task automatic test_glitch();
    int p0;
    int bad;
    apply_reset();
    p0  = n_pulse;
    bad = 0;
    u_if.pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 u_if.pll_locked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((u_if.state !== WAIT_PLL) || (u_if.status !== 4'h0)) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL glitch_state: %0d bad cycles, want 0", bad);
    end
    n_vec++;
    if (n_pulse - p0 !== 0) begin
      n_err++; $display("FAIL glitch_pulses: got %0d want 0", n_pulse - p0);
    end
  endtask

  // Raises PLL and expects CALIBRATING after 7 edges and FAILED 100 later.
  task automatic test_timeout();
    apply_reset();
    u_if.pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL tmo_enter: state=%0d want 1", u_if.state);
    end
    exp_q.push_back(4'h4);
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL tmo_early: state=%0d want 1", u_if.state);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== FAILED) || (u_if.status !== 4'h4)) begin
      n_err++;
      $display("FAIL tmo_fire: state=%0d status=%h want 3/4", u_if.state, u_if.status);
    end
  endtask

  task automatic test_fail_priority();
    apply_reset();
    u_if.pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL pri_cal: state=%0d want 1", u_if.state);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(4'h6);
    u_if.local_init_done   = 1'b1;
    u_if.local_cal_success = 1'b1;
    u_if.local_cal_fail    = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== FAILED) || (u_if.status !== 4'h6)) begin
      n_err++;
      $display("FAIL pri_failed: state=%0d status=%h want 3/6", u_if.state, u_if.status);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(4'h4);
    u_if.local_init_done   = 1'b0;
    u_if.local_cal_success = 1'b0;
    u_if.local_cal_fail    = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== FAILED) || (u_if.status !== 4'h4)) begin
      n_err++;
      $display("FAIL pri_hold: state=%0d status=%h want 3/4", u_if.state, u_if.status);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(4'h0);
    u_if.clear_sticky = 1'b1;
    @(posedge clk);
    #1 u_if.clear_sticky = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== WAIT_PLL) || (u_if.status !== 4'h0)) begin
      n_err++;
      $display("FAIL pri_clear: state=%0d status=%h want 0/0", u_if.state, u_if.status);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL pri_reenter: state=%0d want 1", u_if.state);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL pri_pending: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_pll_loss();
    apply_reset();
    u_if.pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back(4'h3);
    u_if.local_init_done   = 1'b1;
    u_if.local_cal_success = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== READY) || (u_if.status !== 4'h3)) begin
      n_err++;
      $display("FAIL loss_ready: state=%0d status=%h want 2/3", u_if.state, u_if.status);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(4'hA);
    u_if.pll_locked = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== WAIT_PLL) || (u_if.status !== 4'hA)) begin
      n_err++;
      $display("FAIL loss_drop: state=%0d status=%h want 0/a", u_if.state, u_if.status);
    end
    exp_q.push_back(4'hB);
    repeat (3) @(posedge clk);
    #1 u_if.pll_locked = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== READY) || (u_if.status !== 4'hB)) begin
      n_err++;
      $display("FAIL loss_regain: state=%0d status=%h want 2/b", u_if.state, u_if.status);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(4'h3);
    u_if.clear_sticky = 1'b1;
    @(posedge clk);
    #1 u_if.clear_sticky = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== READY) || (u_if.status !== 4'h3)) begin
      n_err++;
      $display("FAIL loss_clear: state=%0d status=%h want 2/3", u_if.state, u_if.status);
    end
    // Second loss with clear_sticky landing on the very cycle the loss is seen.
    @(posedge clk);
    #1;
    exp_q.push_back(4'hA);
    u_if.pll_locked = 1'b0;
    repeat (6) @(posedge clk);
    #1 u_if.clear_sticky = 1'b1;
    @(posedge clk);
    #1 u_if.clear_sticky = 1'b0;
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== WAIT_PLL) || (u_if.status !== 4'hA)) begin
      n_err++;
      $display("FAIL loss_set_wins: state=%0d status=%h want 0/a", u_if.state, u_if.status);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL loss_pending: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_cal();
    apply_reset();
    u_if.pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL mid_cal: state=%0d want 1", u_if.state);
    end
    repeat (50) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if ((u_if.state !== WAIT_PLL) || (u_if.status !== 4'h0) || (u_if.status_change !== 1'b0))
    begin
      n_err++;
      $display("FAIL mid_async: state=%0d status=%h chg=%b want 0/0/0",
               u_if.state, u_if.status, u_if.status_change);
    end
    u_if.pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    u_if.pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL mid_reenter: state=%0d want 1", u_if.state);
    end
    exp_q.push_back(4'h4);
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (u_if.state !== CALIBRATING) begin
      n_err++; $display("FAIL mid_tmo_early: state=%0d want 1", u_if.state);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((u_if.state !== FAILED) || (u_if.status !== 4'h4)) begin
      n_err++;
      $display("FAIL mid_tmo_fire: state=%0d status=%h want 3/4", u_if.state, u_if.status);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_pulse = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_bring_up();
    test_glitch();
    test_timeout();
    test_fail_priority();
    test_pll_loss();
    test_reset_mid_cal();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL final_pending: %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
